// File: rtl/cfa_pkg.sv
// Shared CFA interpolator constants, FSM encoding and window indexing.
// Imported by the gradient pass sequencer and its helpers.
package cfa_pkg;

    localparam int PIX_W  = 12;
    localparam int GRAD_W = PIX_W + 5;
    localparam int WIN_N  = 5;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PV   = 2'd1,
        S_PH   = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [1:0] DIR_EQ = 2'b00;
    localparam logic [1:0] DIR_H  = 2'b01;
    localparam logic [1:0] DIR_V  = 2'b10;

    function automatic int idx(input int r, input int c);
        return WIN_N * r + c;
    endfunction

endpackage

// File: rtl/window_transpose.sv
// Combinational 5x5 window transpose: output pixel (r,c) takes input (c,r).
// Lets the horizontal pass reuse the vertical-gradient datapath.
module window_transpose #(
    parameter int PIX_W = 12
) (
    input  logic [25*PIX_W-1:0] win,
    output logic [25*PIX_W-1:0] win_t
);

    import cfa_pkg::*;

    for (genvar r = 0; r < WIN_N; r++) begin : g_row
        for (genvar c = 0; c < WIN_N; c++) begin : g_col
            assign win_t[idx(r, c)*PIX_W +: PIX_W] =
                win[idx(c, r)*PIX_W +: PIX_W];
        end
    end

endmodule

// File: rtl/grad_pass_sequencer.sv
// Runs one shared gradient datapath twice per window (as-is, then
// transposed) and reports both gradients with a direction decision.
module grad_pass_sequencer #(
    parameter  int PIX_W  = 12,
    parameter  int DP_LAT = 0,
    localparam int GRAD_W = PIX_W + 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                win_valid,
    output logic                win_ready,
    input  logic [25*PIX_W-1:0] win,
    output logic [25*PIX_W-1:0] dp_win,
    input  logic [GRAD_W-1:0]   dp_grad,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [GRAD_W-1:0]   grad_v,
    output logic [GRAD_W-1:0]   grad_h,
    output logic [1:0]          dir
);

    import cfa_pkg::*;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [25*PIX_W-1:0]  win_q;
    logic [25*PIX_W-1:0]  win_t;
    logic                 accept;
    logic                 cap;
    logic [1:0]           dir_nxt;

    window_transpose #(
        .PIX_W (PIX_W)
    ) u_transpose (
        .win   (win_q),
        .win_t (win_t)
    );

    assign win_ready = (state == S_IDLE) ||
                       ((state == S_OUT) && out_ready);
    assign accept    = win_valid && win_ready;
    assign cap       = (cnt == CNT_W'(DP_LAT));

    // dp_grad holds the pass-H gradient in the PH capture cycle
    always_comb begin
        dir_nxt = DIR_EQ;
        if (dp_grad < grad_v) begin
            dir_nxt = DIR_H;
        end else if (grad_v < dp_grad) begin
            dir_nxt = DIR_V;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            win_q     <= '0;
            dp_win    <= '0;
            grad_v    <= '0;
            grad_h    <= '0;
            dir       <= DIR_EQ;
            out_valid <= 1'b0;
        end else if (accept) begin
            win_q     <= win;
            dp_win    <= win;
            cnt       <= '0;
            out_valid <= 1'b0;
            state     <= S_PV;
        end else begin
            unique case (state)
                S_IDLE: begin
                end
                S_PV: begin
                    if (cap) begin
                        grad_v <= dp_grad;
                        dp_win <= win_t;
                        cnt    <= '0;
                        state  <= S_PH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PH: begin
                    if (cap) begin
                        grad_h    <= dp_grad;
                        dir       <= dir_nxt;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= S_OUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
